// File: rtl/uart_tx_arbiter_pkg.sv
// Shared serial package: arbiter state encoding, requester bounds and beat payload.
package uart_tx_arbiter_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned PTR_W   = $clog2(MAX_REQ);
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
  } tx_beat_t;

  // Index of the set bit of a one-hot vector (0 when empty).
  function automatic logic [PTR_W-1:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping to 0.
module rr_select
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_hi_pick;
  logic [N-1:0] w_lo_pick;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (PTR_W'(i) >= i_ptr);
    end
  end

  // Lowest set bit among requests at/above the pointer, else lowest overall.
  assign w_hi      = i_req & w_mask;
  assign w_hi_pick = w_hi & (~w_hi + N'(1));
  assign w_lo_pick = i_req & (~i_req + N'(1));
  assign o_grant   = (|w_hi) ? w_hi_pick : w_lo_pick;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter feeding a UART transmitter from NUM_REQ byte streams,
// with load re-issue on missing busy and forced release of a stalled packet.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned HOLD_TIMEOUT = 65535,
  parameter int unsigned ACK_WAIT     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      pause,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_new_data,
  output logic                      tx_block,
  input  logic                      tx_busy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      timeout
);

  localparam int unsigned HOLD_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam int unsigned ACK_CW = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  tx_beat_t            r_beat;
  tx_beat_t            w_sel_beat;
  logic [NUM_REQ-1:0]  r_grant;
  logic [PTR_W-1:0]    r_ptr;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [ACK_CW-1:0]   r_ack_cnt;
  logic                r_tx_new_data;
  logic                r_tx_block;
  logic                r_timeout;

  logic [NUM_REQ-1:0]  w_rr;
  logic [NUM_REQ-1:0]  w_sel_oh;
  logic                w_accept;
  logic                w_close;
  logic                w_tmo;
  logic [PTR_W-1:0]    w_owner_idx;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic                w_hold_lim;
  logic                w_ack_lim;

  rr_select #(.N(NUM_REQ)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr)
  );

  assign w_hold_lim = (r_hold_cnt == HOLD_W'(HOLD_TIMEOUT - 1));
  assign w_ack_lim  = (r_ack_cnt == ACK_CW'(ACK_WAIT - 1));

  // Next state, accept and packet-close decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_close     = 1'b0;
    w_tmo       = 1'b0;
    w_sel_oh    = '0;
    case (r_state)
      IDLE: begin
        if (|req_valid && !tx_busy && !pause) begin
          w_sel_oh    = w_rr;
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_busy)        w_state_nxt = WAIT_DONE;
        else if (w_ack_lim) w_state_nxt = ISSUE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_beat.last) begin
            w_close     = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (|(req_valid & r_grant) && !tx_busy && !pause) begin
          w_sel_oh    = r_grant;
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end else if (w_hold_lim) begin
          w_close     = 1'b1;
          w_tmo       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel_beat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel_oh[i]) begin
        w_sel_beat.data = req_data[BYTE_W*i +: BYTE_W];
        w_sel_beat.last = req_last[i];
      end
    end
  end

  assign w_owner_idx = oh_to_idx(MAX_REQ'(r_grant));
  assign w_ptr_nxt   = (w_owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_owner_idx + PTR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_beat        <= '0;
      r_grant       <= '0;
      r_ptr         <= '0;
      r_hold_cnt    <= '0;
      r_ack_cnt     <= '0;
      r_tx_new_data <= 1'b0;
      r_tx_block    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tx_new_data <= (w_state_nxt == ISSUE);
      r_tx_block    <= pause;
      r_timeout     <= w_tmo;
      if (w_accept) begin
        r_beat  <= w_sel_beat;
        r_grant <= w_sel_oh;
      end
      if (w_close) begin
        r_grant <= '0;
        r_ptr   <= w_ptr_nxt;
      end
      // Counters run only while staying in their state and saturate at the limit.
      if (r_state == WAIT_ACK && w_state_nxt == WAIT_ACK) begin
        if (!w_ack_lim) r_ack_cnt <= r_ack_cnt + ACK_CW'(1);
      end else begin
        r_ack_cnt <= '0;
      end
      if (r_state == HOLD && w_state_nxt == HOLD) begin
        if (!w_hold_lim) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end else begin
        r_hold_cnt <= '0;
      end
    end
  end

  // Accept strobe is combinational so the requester sees it in the accept cycle.
  assign req_ready   = (rst && w_accept) ? w_sel_oh : '0;
  assign tx_data     = r_beat.data;
  assign tx_new_data = r_tx_new_data;
  assign tx_block    = r_tx_block;
  assign grant       = r_grant;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: packet-level model plus transmitter model, checked every cycle.
module tb_uart_tx_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned HT       = 8;
  localparam int unsigned AW       = 3;
  localparam int unsigned BUSY_LEN = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           pause = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_new_data;
  logic           tx_block;
  logic           tx_busy = 1'b0;
  logic [N-1:0]   grant;
  logic           timeout;

  uart_tx_arbiter #(.NUM_REQ(N), .HOLD_TIMEOUT(HT), .ACK_WAIT(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .pause       (pause),
    .tx_data     (tx_data),
    .tx_new_data (tx_new_data),
    .tx_block    (tx_block),
    .tx_busy     (tx_busy),
    .grant       (grant),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // requester byte queues {last, data}
  logic [8:0] qd [N][16];
  int qhead [N];
  int qtail [N];

  // applied at the next falling edge so the model sees them in the right cycle
  logic rst_nxt = 1'b0;
  logic pause_nxt = 1'b0;

  // transmitter model
  logic pend = 1'b0;
  int busy_cnt = 0;
  int drop_acks = 0;

  // packet model
  int         m_ptr, m_owner, m_zc, m_hc;
  logic       m_open, m_last_acc, m_in_flight, m_busy_seen, m_holding, m_waiting;
  logic [7:0] m_byte;
  logic       exp_strobe, exp_timeout, prev_pause;
  logic [7:0] exp_byte;
  logic [N-1:0] exp_grant;

  // observed strobe log
  logic [7:0]   lg_data [64];
  logic [N-1:0] lg_grant [64];
  int           lg_cyc [64];
  int n_log = 0;
  int n_acc = 0;
  int n_tmo = 0;
  int tmo_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
    logic [N-1:0] r;
    logic found;
    r = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (!found && v[idx]) begin
        r[idx] = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_zc = 0; m_hc = 0;
    m_open = 0; m_last_acc = 0; m_in_flight = 0; m_busy_seen = 0;
    m_holding = 0; m_waiting = 0; m_byte = '0;
    exp_strobe = 0; exp_timeout = 0; exp_byte = '0; exp_grant = '0; prev_pause = 0;
    pend = 0; busy_cnt = 0; drop_acks = 0; tx_busy = 1'b0;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qd[r][qtail[r]] = {l, d};
    qtail[r]++;
  endtask

  task automatic step();
    logic [N-1:0] exp_ready;
    logic nxt_strobe, nxt_tmo;
    logic [7:0] nxt_byte;
    int a;
    @(negedge clk);
    cyc++;
    rst = rst_nxt;
    pause = pause_nxt;
    if (pend && rst) begin
      if (drop_acks > 0) drop_acks--;
      else busy_cnt = BUSY_LEN;
    end
    tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    for (int i = 0; i < N; i++) begin
      if (qhead[i] != qtail[i]) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = qd[i][qhead[i]][7:0];
        req_last[i] = qd[i][qhead[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
    #1;
    if (!rst) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_tx_new_data", 32'(tx_new_data), 0);
      chk("rst_tx_data", 32'(tx_data), 0);
      chk("rst_tx_block", 32'(tx_block), 0);
      chk("rst_timeout", 32'(timeout), 0);
      prev_pause = pause;
      pend = 1'b0;
      return;
    end

    chk("tx_new_data", 32'(tx_new_data), 32'(exp_strobe));
    if (exp_strobe) chk("tx_data", 32'(tx_data), 32'(exp_byte));
    chk("grant", 32'(grant), 32'(exp_grant));
    chk("timeout", 32'(timeout), 32'(exp_timeout));
    chk("tx_block", 32'(tx_block), 32'(prev_pause));

    if (tx_new_data && n_log < 64) begin
      lg_data[n_log] = tx_data;
      lg_grant[n_log] = grant;
      lg_cyc[n_log] = cyc;
      n_log++;
    end
    if (timeout) begin
      n_tmo++;
      tmo_cyc = cyc;
    end

    exp_ready = '0;
    if (!m_in_flight && !tx_busy && !pause) begin
      if (!m_open) exp_ready = rr_pick(req_valid, m_ptr);
      else if (m_holding && req_valid[m_owner]) exp_ready[m_owner] = 1'b1;
    end
    chk("req_ready", 32'(req_ready), 32'(exp_ready));

    nxt_strobe = 1'b0;
    nxt_tmo = 1'b0;
    nxt_byte = m_byte;
    if (|exp_ready) begin
      a = 0;
      for (int i = 0; i < N; i++) if (exp_ready[i]) a = i;
      if (!m_open) begin
        m_open = 1'b1;
        m_owner = a;
        exp_grant = '0;
        exp_grant[a] = 1'b1;
      end
      m_byte = req_data[8*a +: 8];
      m_last_acc = req_last[a];
      m_in_flight = 1'b1;
      m_busy_seen = 1'b0;
      m_waiting = 1'b0;
      m_holding = 1'b0;
      n_acc++;
      nxt_strobe = 1'b1;
      nxt_byte = m_byte;
    end else if (m_in_flight) begin
      if (exp_strobe) begin
        m_waiting = 1'b1;
        m_zc = 0;
      end else if (m_waiting) begin
        if (tx_busy) begin
          m_waiting = 1'b0;
          m_busy_seen = 1'b1;
        end else begin
          m_zc++;
          if (m_zc == AW) nxt_strobe = 1'b1;
        end
      end else if (m_busy_seen && !tx_busy) begin
        m_in_flight = 1'b0;
        if (m_last_acc) begin
          m_open = 1'b0;
          m_ptr = (m_owner + 1) % N;
          exp_grant = '0;
        end else begin
          m_holding = 1'b1;
          m_hc = 0;
        end
      end
    end else if (m_holding) begin
      m_hc++;
      if (m_hc == HT) begin
        nxt_tmo = 1'b1;
        m_holding = 1'b0;
        m_open = 1'b0;
        m_ptr = (m_owner + 1) % N;
        exp_grant = '0;
      end
    end

    for (int i = 0; i < N; i++) if (req_ready[i] && req_valid[i]) qhead[i]++;
    exp_strobe = nxt_strobe;
    exp_byte = nxt_byte;
    exp_timeout = nxt_tmo;
    prev_pause = pause;
    pend = tx_new_data;
  endtask

  task automatic run_to(input int target, input int budget);
    int n;
    n = 0;
    while (n_log < target && n < budget) begin
      step();
      n++;
    end
    if (n_log < target) chk("run_to_budget", 32'(n_log), 32'(target));
  endtask

  task automatic run_quiet(input int target, input int budget);
    int n;
    n = 0;
    while ((n_log < target || m_open || m_in_flight) && n < budget) begin
      step();
      n++;
    end
    chk("quiet_strobes", 32'(n_log), 32'(target));
    chk("quiet_closed", 32'({m_open, m_in_flight}), 0);
  endtask

  task automatic chk_log(input int idx, input logic [7:0] d, input logic [N-1:0] g);
    chk("log_data", 32'(lg_data[idx]), 32'(d));
    chk("log_grant", 32'(lg_grant[idx]), 32'(g));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, acc0, tmo0;
    for (int i = 0; i < N; i++) begin
      qhead[i] = 0;
      qtail[i] = 0;
    end
    model_reset();
    #1 rst = 1'b0;
    rst_nxt = 1'b0;
    repeat (3) step();
    rst_nxt = 1'b1;

    // two single-byte packets, priority from requester 0
    base = n_log;
    push(0, 8'hA5, 1'b1);
    push(2, 8'h3C, 1'b1);
    run_quiet(base + 2, 80);
    chk_log(base, 8'hA5, 4'b0001);
    chk_log(base + 1, 8'h3C, 4'b0100);

    // multi-byte packet holds the grant; pause during a byte stalls, never aborts
    base = n_log;
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    step();
    step();
    push(3, 8'h44, 1'b1);
    run_to(base + 2, 80);
    pause_nxt = 1'b1;
    repeat (6) step();
    pause_nxt = 1'b0;
    run_quiet(base + 4, 120);
    chk_log(base, 8'h11, 4'b0010);
    chk_log(base + 1, 8'h22, 4'b0010);
    chk_log(base + 2, 8'h33, 4'b0010);
    chk_log(base + 3, 8'h44, 4'b1000);
    chk("no_timeout_t2", 32'(n_tmo), 0);

    // missing busy: same byte re-strobed after ACK_WAIT idle cycles, one accept
    base = n_log;
    acc0 = n_acc;
    drop_acks = 1;
    push(0, 8'h5A, 1'b1);
    run_quiet(base + 2, 80);
    chk_log(base, 8'h5A, 4'b0001);
    chk_log(base + 1, 8'h5A, 4'b0001);
    chk("restrobe_gap", 32'(lg_cyc[base + 1] - lg_cyc[base]), 4);
    chk("restrobe_accepts", 32'(n_acc - acc0), 1);

    // silent owner released by timeout, requester 1 served next
    base = n_log;
    tmo0 = n_tmo;
    push(0, 8'h77, 1'b0);
    run_to(base + 1, 40);
    push(1, 8'h88, 1'b1);
    run_quiet(base + 2, 120);
    chk_log(base, 8'h77, 4'b0001);
    chk_log(base + 1, 8'h88, 4'b0010);
    chk("timeout_count", 32'(n_tmo - tmo0), 1);
    chk("timeout_cycle", 32'(tmo_cyc - lg_cyc[base]), 13);
    chk("post_tmo_strobe", 32'(lg_cyc[base + 1] - lg_cyc[base]), 14);

    // reset during WAIT_DONE drops the packet and restores requester-0 priority
    base = n_log;
    push(2, 8'h99, 1'b0);
    run_to(base + 1, 40);
    chk_log(base, 8'h99, 4'b0100);
    pause_nxt = 1'b1;
    step();
    step();
    chk("pre_rst_block", 32'(tx_block), 1);
    #2;
    rst = 1'b0;
    rst_nxt = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 0);
    chk("async_tx_data", 32'(tx_data), 0);
    chk("async_tx_block", 32'(tx_block), 0);
    chk("async_tx_new_data", 32'(tx_new_data), 0);
    chk("async_timeout", 32'(timeout), 0);
    chk("async_req_ready", 32'(req_ready), 0);
    model_reset();
    pause_nxt = 1'b0;
    push(0, 8'hAA, 1'b1);
    push(3, 8'hBB, 1'b1);
    repeat (3) step();
    rst_nxt = 1'b1;
    base = n_log;
    run_quiet(base + 2, 80);
    chk_log(base, 8'hAA, 4'b0001);
    chk_log(base + 1, 8'hBB, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
